// File: rtl/ni_packetizer.sv
// ni_packetizer
// Local-port network interface transmitter. Payload words are buffered in a
// FIFO. On request they are sent to the router Local input as one packet:
// a header flit, N body flits and a tail flit. Every flit carries even parity
// in bit 0. Flits are offered with RTS and advance only when DCTS is high.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   cur_addr      own router address (header source field)
//   wr_en/wr_data push a 28-bit payload word into the FIFO
//   wr_err        one-cycle pulse when a push is dropped because the FIFO is full
//   buf_count     number of words held; buf_full when it equals DEPTH
//   send_req      start a packet of send_len body words to send_dst
//   send_err      one-cycle pulse when a request is rejected
//   busy          a packet is in progress
//   done          one-cycle pulse after the tail flit is transferred
//   TX/RTS        flit and flit-valid to router L_RX / L_DRTS
//   DCTS          router L_CTS
module ni_packetizer #(
   parameter int DATA_WIDTH = 32,
   parameter int AXIS       = 4,
   parameter int DEPTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [AXIS-1:0]           cur_addr,
   input  logic                      wr_en,
   input  logic [27:0]               wr_data,
   output logic                      wr_err,
   output logic [$clog2(DEPTH):0]    buf_count,
   output logic                      buf_full,
   input  logic                      send_req,
   input  logic [AXIS-1:0]           send_dst,
   input  logic [$clog2(DEPTH):0]    send_len,
   output logic                      send_err,
   output logic                      busy,
   output logic                      done,
   output logic [DATA_WIDTH-1:0]     TX,
   output logic                      RTS,
   input  logic                      DCTS
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, HEADER, BODY, TAIL} state_t;

   state_t          state;
   logic [7:0]      pkt_id;
   logic [CW-1:0]   remaining;

   logic [27:0]     mem [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [CW-1:0]   count_next;
   logic            push_ok;
   logic            pop;
   logic [27:0]     head_word;
   logic [27:0]     next_word;

   // ---------------- flit builders ----------------
   function automatic logic [DATA_WIDTH-1:0] make_header(
      input logic [CW-1:0]   n,
      input logic [AXIS-1:0] dst,
      input logic [AXIS-1:0] src,
      input logic [7:0]      id);
      logic [DATA_WIDTH-1:0] f;
      f        = '0;
      f[31:29] = 3'b001;
      f[28:17] = 12'(n) + 12'd2;
      f[16:13] = dst;
      f[12:9]  = src;
      f[8:1]   = id;
      f[0]     = ^f[DATA_WIDTH-1:1];
      return f;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] make_body(input logic [27:0] w);
      logic [DATA_WIDTH-1:0] f;
      f        = '0;
      f[31:29] = 3'b010;
      f[28:1]  = w;
      f[0]     = ^f[DATA_WIDTH-1:1];
      return f;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] make_tail();
      logic [DATA_WIDTH-1:0] f;
      f        = '0;
      f[31:29] = 3'b100;
      f[0]     = ^f[DATA_WIDTH-1:1];
      return f;
   endfunction

   // ---------------- payload FIFO ----------------
   // Fullness is judged on the registered count, so a push while full is
   // dropped even if the same edge pops a word.
   assign push_ok   = wr_en && (buf_count != CW'(DEPTH));
   assign pop       = (state == BODY) && DCTS;
   assign head_word = mem[rd_ptr];
   // Word after the one being popped; feeds the next body flit.
   assign next_word = mem[rd_ptr + AW'(1)];

   always_comb begin
      count_next = buf_count;
      if (push_ok && !pop)
         count_next = buf_count + CW'(1);
      else if (!push_ok && pop)
         count_next = buf_count - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         buf_count <= '0;
         buf_full  <= 1'b0;
         wr_err    <= 1'b0;
      end else begin
         wr_err    <= wr_en && !push_ok;
         buf_count <= count_next;
         buf_full  <= (count_next == CW'(DEPTH));
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
      end
   end

   // ---------------- packet sequencer ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         TX        <= '0;
         RTS       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         send_err  <= 1'b0;
         pkt_id    <= '0;
         remaining <= '0;
      end else begin
         done     <= 1'b0;
         send_err <= 1'b0;
         case (state)
            IDLE: begin
               if (send_req) begin
                  if (send_len != '0 && send_len <= buf_count) begin
                     TX        <= make_header(send_len, send_dst, cur_addr, pkt_id);
                     RTS       <= 1'b1;
                     busy      <= 1'b1;
                     remaining <= send_len;
                     state     <= HEADER;
                  end else begin
                     send_err <= 1'b1;
                  end
               end
            end
            HEADER: begin
               if (DCTS) begin
                  TX    <= make_body(head_word);
                  state <= BODY;
               end
            end
            BODY: begin
               if (DCTS) begin
                  remaining <= remaining - CW'(1);
                  if (remaining == CW'(1)) begin
                     TX    <= make_tail();
                     state <= TAIL;
                  end else begin
                     TX <= make_body(next_word);
                  end
               end
            end
            TAIL: begin
               if (DCTS) begin
                  TX     <= '0;
                  RTS    <= 1'b0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  pkt_id <= pkt_id + 8'd1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ni_packetizer.sv
// Testbench for ni_packetizer: stimulus pushes expected flits into a
// scoreboard queue; a negedge monitor pops and compares on every transfer
// (RTS && DCTS) and checks that stalled flits hold steady.
module tb_ni_packetizer;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  cur_addr;
   logic        wr_en;
   logic [27:0] wr_data;
   logic        wr_err;
   logic [4:0]  buf_count;
   logic        buf_full;
   logic        send_req;
   logic [3:0]  send_dst;
   logic [4:0]  send_len;
   logic        send_err;
   logic        busy;
   logic        done;
   logic [31:0] TX;
   logic        RTS;
   logic        DCTS;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] sb[$];
   logic        prev_stall = 1'b0;
   logic [31:0] prev_tx = '0;

   ni_packetizer #(.DATA_WIDTH(32), .AXIS(4), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .cur_addr(cur_addr),
      .wr_en(wr_en), .wr_data(wr_data), .wr_err(wr_err),
      .buf_count(buf_count), .buf_full(buf_full),
      .send_req(send_req), .send_dst(send_dst), .send_len(send_len),
      .send_err(send_err), .busy(busy), .done(done),
      .TX(TX), .RTS(RTS), .DCTS(DCTS)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected flit model: header length field N+2 at [28:17]
   function automatic logic [31:0] hdr(input int n, input logic [3:0] dst,
                                       input logic [3:0] src, input logic [7:0] id);
      logic [31:0] f;
      f = {3'b001, 12'(n + 2), dst, src, id, 1'b0};
      f[0] = ^f;
      return f;
   endfunction

   function automatic logic [31:0] bdy(input logic [27:0] w);
      logic [31:0] f;
      f = {3'b010, w, 1'b0};
      f[0] = ^f;
      return f;
   endfunction

   localparam logic [31:0] TAIL_FLIT = 32'h8000_0001;

   // Monitor
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_rts", {31'd0, RTS}, 32'd1);
            chk("hold_tx", TX, prev_tx);
         end
         if (RTS && DCTS) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_flit: got %h expected none", TX);
            end else begin
               chk("flit", TX, sb.pop_front());
               chk("parity", {31'd0, ^TX}, 32'd0);
            end
         end
         prev_stall = RTS && !DCTS;
         prev_tx    = TX;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [27:0] w);
      wr_en   = 1'b1;
      wr_data = w;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic send(input int len, input logic [3:0] dst);
      send_dst = dst;
      send_len = 5'(len);
      send_req = 1'b1;
      tick();
      send_req = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      while (!done && k < 200) begin
         tick();
         k++;
      end
      chk({name, "_done"}, {31'd0, done}, 32'd1);
      chk({name, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; cur_addr = 4'h2; wr_en = 1'b0; wr_data = '0;
      send_req = 1'b0; send_dst = '0; send_len = '0; DCTS = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tx", TX, 32'd0);
      chk("rst_rts", {31'd0, RTS}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_count", {27'd0, buf_count}, 32'd0);
      chk("rst_full", {31'd0, buf_full}, 32'd0);
      chk("rst_errs", {30'd0, wr_err, send_err}, 32'd0);
      rst = 1'b0;
      tick();

      // Basic 3-word packet, hand-computed flits
      push(28'h0000001); push(28'h0000002); push(28'h0000003);
      tick();
      chk("t1_count", {27'd0, buf_count}, 32'd3);
      sb.push_back(32'h200A_A400);
      sb.push_back(32'h4000_0002);
      sb.push_back(32'h4000_0004);
      sb.push_back(32'h4000_0007);
      sb.push_back(TAIL_FLIT);
      send(3, 4'h5);
      for (int i = 0; i < 5; i++) begin
         chk("t1_rts_run", {31'd0, RTS}, 32'd1);
         tick();
      end
      chk("t1_done", {31'd0, done}, 32'd1);
      chk("t1_busy", {31'd0, busy}, 32'd0);
      chk("t1_rts_off", {31'd0, RTS}, 32'd0);
      chk("t1_tx_off", TX, 32'd0);
      chk("t1_count0", {27'd0, buf_count}, 32'd0);
      tick();
      chk("t1_done_pulse", {31'd0, done}, 32'd0);

      // Same packet with a 4-cycle stall in BODY (pkt_id 1)
      push(28'h0000001); push(28'h0000002); push(28'h0000003);
      sb.push_back(32'h200A_A403);
      sb.push_back(32'h4000_0002);
      sb.push_back(32'h4000_0004);
      sb.push_back(32'h4000_0007);
      sb.push_back(TAIL_FLIT);
      send(3, 4'h5);
      tick();
      tick();
      DCTS = 1'b0;
      repeat (4) tick();
      DCTS = 1'b1;
      wait_done("t2");

      // Rejected requests
      push(28'hABCDEF0); push(28'h1234567);
      tick();
      chk("t3_count", {27'd0, buf_count}, 32'd2);
      send(4, 4'h5);
      chk("t3_err_long", {31'd0, send_err}, 32'd1);
      chk("t3_busy_long", {31'd0, busy}, 32'd0);
      chk("t3_rts_long", {31'd0, RTS}, 32'd0);
      tick();
      chk("t3_err_pulse", {31'd0, send_err}, 32'd0);
      send(0, 4'h5);
      chk("t3_err_zero", {31'd0, send_err}, 32'd1);
      chk("t3_busy_zero", {31'd0, busy}, 32'd0);
      tick();
      // Drain the two words (pkt_id 2)
      sb.push_back(hdr(2, 4'h5, 4'h2, 8'd2));
      sb.push_back(bdy(28'hABCDEF0));
      sb.push_back(bdy(28'h1234567));
      sb.push_back(TAIL_FLIT);
      send(2, 4'h5);
      wait_done("t3");

      // FIFO overflow, then push+pop while full (pkt_id 3)
      for (int i = 0; i <= DEPTH; i++) begin
         wr_en = 1'b1;
         wr_data = 28'(i + 'h100);
         tick();
         chk("t4_wr_err", {31'd0, wr_err}, (i == DEPTH) ? 32'd1 : 32'd0);
      end
      wr_en = 1'b0;
      tick();
      chk("t4_wr_err_pulse", {31'd0, wr_err}, 32'd0);
      chk("t4_count", {27'd0, buf_count}, 32'(DEPTH));
      chk("t4_full", {31'd0, buf_full}, 32'd1);
      sb.push_back(hdr(DEPTH, 4'h9, 4'h2, 8'd3));
      for (int i = 0; i < DEPTH; i++) sb.push_back(bdy(28'(i + 'h100)));
      sb.push_back(TAIL_FLIT);
      send(DEPTH, 4'h9);
      tick();
      wr_en = 1'b1;
      wr_data = 28'hFFFFFFF;
      tick();
      wr_en = 1'b0;
      chk("t4_pushpop_err", {31'd0, wr_err}, 32'd1);
      chk("t4_pushpop_count", {27'd0, buf_count}, 32'(DEPTH - 1));
      wait_done("t4");
      chk("t4_count_end", {27'd0, buf_count}, 32'd0);

      // Reset in BODY
      push(28'h0000011); push(28'h0000022); push(28'h0000033);
      sb.push_back(hdr(3, 4'h5, 4'h2, 8'd4));
      send(3, 4'h5);
      tick();
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rts", {31'd0, RTS}, 32'd0);
      chk("t6_tx", TX, 32'd0);
      chk("t6_count", {27'd0, buf_count}, 32'd0);
      chk("t6_busy", {31'd0, busy}, 32'd0);
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      chk("t6_no_done", {31'd0, done}, 32'd0);
      push(28'h0000055);
      sb.push_back(hdr(1, 4'h3, 4'h2, 8'd0));
      sb.push_back(bdy(28'h0000055));
      sb.push_back(TAIL_FLIT);
      send(1, 4'h3);
      wait_done("t6");

      // 256 one-word packets: ids 1..255 then wrap to 0
      for (int p = 1; p <= 256; p++) begin
         logic [7:0] id;
         id = 8'(p);
         push(28'(p * 7 + 3));
         sb.push_back(hdr(1, 4'hA, 4'h2, id));
         sb.push_back(bdy(28'(p * 7 + 3)));
         sb.push_back(TAIL_FLIT);
         send(1, 4'hA);
         wait_done("t5");
      end

      tick();
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
